// File: rtl/mam_wb_pkg.sv
// mam_wb_pkg: shared types and defaults for the MAM/CPU Wishbone scheduler
package mam_wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAM,
        S_CPU,
        S_ABORT
    } state_e;

    localparam int DEF_MAX_WAIT = 16;
    localparam int DEF_TIMEOUT  = 255;

    // Byte-select width for a given data width
    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mam_wb_watchdog.sv
// mam_wb_watchdog: counts stalled memory strobes and flags the abort cycle
module mam_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rstn_i,
    input  logic armed_i,
    input  logic stall_i,
    input  logic resp_i,
    output logic expired_o
);

    localparam int WW = $clog2(TIMEOUT + 2);

    logic [WW-1:0] wd_cnt_q, wd_cnt_d;

    // The counter only runs while an owner holds the bus; any response restarts it
    assign expired_o = armed_i && (wd_cnt_q == WW'(TIMEOUT));

    // Next count: clear when unowned or on a response, count stalls up to TIMEOUT
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (!armed_i || resp_i)
            wd_cnt_d = '0;
        else if (stall_i && !expired_o)
            wd_cnt_d = wd_cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i)
            wd_cnt_q <= '0;
        else
            wd_cnt_q <= wd_cnt_d;
    end

endmodule

// File: rtl/mam_wb_scheduler.sv
// mam_wb_scheduler: arbitrates CPU and MAM Wishbone masters onto one memory port
module mam_wb_scheduler
    import mam_wb_pkg::*;
#(
    parameter int  AW       = 32,
    parameter int  DW       = 32,
    parameter int  MAX_WAIT = DEF_MAX_WAIT,
    parameter int  TIMEOUT  = DEF_TIMEOUT,
    localparam int SW       = sel_width(DW)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rstn_i,
    input  logic [AW-1:0] cpu_adr_i,
    input  logic [DW-1:0] cpu_dat_i,
    input  logic [SW-1:0] cpu_sel_i,
    input  logic          cpu_we_i,
    input  logic          cpu_cyc_i,
    input  logic          cpu_stb_i,
    input  logic [2:0]    cpu_cti_i,
    input  logic [1:0]    cpu_bte_i,
    output logic          cpu_ack_o,
    output logic          cpu_err_o,
    output logic          cpu_rty_o,
    output logic [DW-1:0] cpu_dat_o,
    input  logic [AW-1:0] mam_adr_i,
    input  logic [DW-1:0] mam_dat_i,
    input  logic [SW-1:0] mam_sel_i,
    input  logic          mam_we_i,
    input  logic          mam_cyc_i,
    input  logic          mam_stb_i,
    input  logic [2:0]    mam_cti_i,
    input  logic [1:0]    mam_bte_i,
    output logic          mam_ack_o,
    output logic          mam_err_o,
    output logic          mam_rty_o,
    output logic [DW-1:0] mam_dat_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [DW-1:0] mem_dat_o,
    output logic [SW-1:0] mem_sel_o,
    output logic          mem_we_o,
    output logic          mem_cyc_o,
    output logic          mem_stb_o,
    output logic [2:0]    mem_cti_o,
    output logic [1:0]    mem_bte_o,
    input  logic          mem_ack_i,
    input  logic          mem_err_i,
    input  logic          mem_rty_i,
    input  logic [DW-1:0] mem_dat_i,
    output logic [1:0]    grant_o,
    output logic          timeout_o
);

    localparam int SCW = $clog2(MAX_WAIT + 2);

    state_e         state_q, state_d;
    logic           owner_cpu_q, owner_cpu_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic           live, own_cpu, fwd, starved, wd_expired;
    logic           resp_ack, resp_err, resp_rty;
    logic [DW-1:0]  resp_dat;

    // live: an owner is connected; fwd: it is connected and not being aborted this cycle
    assign live    = (state_q == S_MAM) || (state_q == S_CPU);
    assign own_cpu = state_q == S_CPU;
    assign fwd     = live && !wd_expired;
    assign starved = starve_q == SCW'(MAX_WAIT);

    assign timeout_o = wd_expired;

    mam_wb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .wb_clk_i (wb_clk_i),
        .wb_rstn_i(wb_rstn_i),
        .armed_i  (live),
        .stall_i  (mem_cyc_o && mem_stb_o),
        .resp_i   (mem_ack_i || mem_err_i || mem_rty_i),
        .expired_o(wd_expired)
    );

    // Pass the owner's request to memory and route responses back to the owner only
    always_comb begin
        mem_adr_o = live ? (own_cpu ? cpu_adr_i : mam_adr_i) : '0;
        mem_dat_o = live ? (own_cpu ? cpu_dat_i : mam_dat_i) : '0;
        mem_sel_o = live ? (own_cpu ? cpu_sel_i : mam_sel_i) : '0;
        mem_we_o  = live && (own_cpu ? cpu_we_i : mam_we_i);
        mem_cti_o = live ? (own_cpu ? cpu_cti_i : mam_cti_i) : '0;
        mem_bte_o = live ? (own_cpu ? cpu_bte_i : mam_bte_i) : '0;
        mem_cyc_o = fwd && (own_cpu ? cpu_cyc_i : mam_cyc_i);
        mem_stb_o = fwd && (own_cpu ? cpu_stb_i : mam_stb_i);
        resp_ack  = fwd && mem_ack_i;
        resp_err  = live && (wd_expired || mem_err_i);
        resp_rty  = fwd && mem_rty_i;
        resp_dat  = fwd ? mem_dat_i : '0;
        cpu_ack_o = own_cpu && resp_ack;
        cpu_err_o = own_cpu && resp_err;
        cpu_rty_o = own_cpu && resp_rty;
        cpu_dat_o = own_cpu ? resp_dat : '0;
        mam_ack_o = !own_cpu && resp_ack;
        mam_err_o = !own_cpu && resp_err;
        mam_rty_o = !own_cpu && resp_rty;
        mam_dat_o = own_cpu ? '0 : resp_dat;
        grant_o   = {own_cpu, state_q == S_MAM};
    end

    // Next state: arbitrate in IDLE, hold the owner until its cyc drops, abort on watchdog expiry
    always_comb begin
        state_d     = state_q;
        owner_cpu_d = live ? own_cpu : owner_cpu_q;
        starve_d    = starve_q;
        case (state_q)
            S_IDLE: begin
                state_d  = (starved && cpu_cyc_i) ? S_CPU :
                           mam_cyc_i              ? S_MAM :
                           cpu_cyc_i              ? S_CPU : S_IDLE;
                starve_d = (state_d == S_CPU) ? '0 : starve_q;
            end
            S_MAM: begin
                state_d  = wd_expired ? S_ABORT : mam_cyc_i ? S_MAM : S_IDLE;
                starve_d = (cpu_cyc_i && !starved) ? starve_q + 1'b1 : starve_q;
            end
            S_CPU:   state_d = wd_expired ? S_ABORT : cpu_cyc_i ? S_CPU : S_IDLE;
            default: state_d = (owner_cpu_q ? cpu_cyc_i : mam_cyc_i) ? S_ABORT : S_IDLE;
        endcase
    end

    // State, owner memory and starvation counter registers
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q     <= S_IDLE;
            owner_cpu_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_cpu_q <= owner_cpu_d;
            starve_q    <= starve_d;
        end
    end

endmodule

// File: tb/tb_mam_wb_scheduler.sv
// tb_mam_wb_scheduler: directed vector table plus multi-cycle corner sequences
module tb_mam_wb_scheduler;

    localparam logic [31:0] A_C = 32'h0000_1000;
    localparam logic [31:0] A_M = 32'h0000_2000;
    localparam logic [31:0] D   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] cpu_adr, cpu_dat, mam_adr, mam_dat, mem_dat_i;
    logic [3:0]  cpu_sel, mam_sel;
    logic        cpu_we, cpu_cyc, cpu_stb, mam_we, mam_cyc, mam_stb;
    logic [2:0]  cpu_cti, mam_cti;
    logic [1:0]  cpu_bte, mam_bte;
    logic        mem_ack, mem_err, mem_rty;
    logic        cpu_ack_o, cpu_err_o, cpu_rty_o, mam_ack_o, mam_err_o, mam_rty_o;
    logic [31:0] cpu_dat_o, mam_dat_o, mem_adr_o, mem_dat_o;
    logic [3:0]  mem_sel_o;
    logic        mem_we_o, mem_cyc_o, mem_stb_o, timeout_o;
    logic [2:0]  mem_cti_o;
    logic [1:0]  mem_bte_o, grant_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mam_wb_scheduler #(
        .AW(32), .DW(32), .MAX_WAIT(16), .TIMEOUT(8)
    ) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_sel_i(cpu_sel), .cpu_we_i(cpu_we),
        .cpu_cyc_i(cpu_cyc), .cpu_stb_i(cpu_stb), .cpu_cti_i(cpu_cti), .cpu_bte_i(cpu_bte),
        .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o), .cpu_rty_o(cpu_rty_o), .cpu_dat_o(cpu_dat_o),
        .mam_adr_i(mam_adr), .mam_dat_i(mam_dat), .mam_sel_i(mam_sel), .mam_we_i(mam_we),
        .mam_cyc_i(mam_cyc), .mam_stb_i(mam_stb), .mam_cti_i(mam_cti), .mam_bte_i(mam_bte),
        .mam_ack_o(mam_ack_o), .mam_err_o(mam_err_o), .mam_rty_o(mam_rty_o), .mam_dat_o(mam_dat_o),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_sel_o(mem_sel_o), .mem_we_o(mem_we_o),
        .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_cti_o(mem_cti_o), .mem_bte_o(mem_bte_o),
        .mem_ack_i(mem_ack), .mem_err_i(mem_err), .mem_rty_i(mem_rty), .mem_dat_i(mem_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    typedef struct {
        logic        mc, cc, ack;
        logic [1:0]  grant;
        logic        mcyc;
        logic [31:0] adr;
        logic        cack, mack;
        logic [31:0] cdat, mdat;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mkv(input logic mc, input logic cc, input logic ack,
                                 input logic [1:0] g, input logic mcyc, input logic [31:0] adr,
                                 input logic cack, input logic mack,
                                 input logic [31:0] cdat, input logic [31:0] mdat);
        vec_t v;
        v.mc = mc; v.cc = cc; v.ack = ack; v.grant = g; v.mcyc = mcyc; v.adr = adr;
        v.cack = cack; v.mack = mack; v.cdat = cdat; v.mdat = mdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mc, input logic cc, input logic ack);
        mam_cyc = mc; mam_stb = mc;
        cpu_cyc = cc; cpu_stb = cc;
        mem_ack = ack;
    endtask

    initial begin
        cpu_adr = A_C; mam_adr = A_M; cpu_dat = 32'h1111_1111; mam_dat = 32'h2222_2222;
        cpu_sel = 4'hF; mam_sel = 4'h3; cpu_we = 1'b0; mam_we = 1'b0;
        cpu_cti = 3'b000; mam_cti = 3'b000; cpu_bte = 2'b00; mam_bte = 2'b00;
        mem_err = 1'b0; mem_rty = 1'b0; mem_dat_i = D;
        drive(1'b0, 1'b0, 1'b0);

        vt[0]  = mkv(0, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        vt[1]  = mkv(1, 1, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        vt[2]  = mkv(1, 1, 0, 2'b01, 1, A_M,   0, 0, 32'h0, D);
        vt[3]  = mkv(1, 1, 1, 2'b01, 1, A_M,   0, 1, 32'h0, D);
        vt[4]  = mkv(0, 1, 0, 2'b01, 0, A_M,   0, 0, 32'h0, D);
        vt[5]  = mkv(0, 1, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        vt[6]  = mkv(1, 1, 1, 2'b10, 1, A_C,   1, 0, D,     32'h0);
        vt[7]  = mkv(1, 0, 0, 2'b10, 0, A_C,   0, 0, D,     32'h0);
        vt[8]  = mkv(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        vt[9]  = mkv(0, 0, 0, 2'b01, 0, A_M,   0, 0, 32'h0, D);
        vt[10] = mkv(0, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0, 32'h0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst grant", 32'(grant_o), 0);
        chk("rst mem_cyc", 32'(mem_cyc_o), 0);
        chk("rst timeout", 32'(timeout_o), 0);
        chk("rst cpu_err", 32'(cpu_err_o), 0);
        rstn = 1'b1;

        // table: arbitration, routing, idle gaps
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].mc, vt[i].cc, vt[i].ack);
            @(negedge clk);
            chk($sformatf("vec%0d grant", i), 32'(grant_o), 32'(vt[i].grant));
            chk($sformatf("vec%0d mem_cyc", i), 32'(mem_cyc_o), 32'(vt[i].mcyc));
            chk($sformatf("vec%0d mem_adr", i), mem_adr_o, vt[i].adr);
            chk($sformatf("vec%0d cpu_ack", i), 32'(cpu_ack_o), 32'(vt[i].cack));
            chk($sformatf("vec%0d mam_ack", i), 32'(mam_ack_o), 32'(vt[i].mack));
            chk($sformatf("vec%0d cpu_dat", i), cpu_dat_o, vt[i].cdat);
            chk($sformatf("vec%0d mam_dat", i), mam_dat_o, vt[i].mdat);
            tick();
        end

        // starvation: MAM holds 40 cycles, CPU wins after release despite MAM reasserting
        drive(1'b1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20 || i == 39) chk($sformatf("starve hold%0d grant", i), 32'(grant_o), 1);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("starve last grant", 32'(grant_o), 1);
        tick();
        drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("starve gap grant", 32'(grant_o), 0);
        tick();
        @(negedge clk);
        chk("starve cpu grant", 32'(grant_o), 2);
        chk("starve cpu_ack", 32'(cpu_ack_o), 1);
        chk("starve mam_ack", 32'(mam_ack_o), 0);
        drive(1'b1, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        chk("starve post gap", 32'(grant_o), 0);
        tick();
        @(negedge clk);
        chk("starve mam back", 32'(grant_o), 1);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // CPU 4-beat burst with MAM request mid-burst
        drive(1'b0, 1'b1, 1'b0);
        cpu_cti = 3'b010;
        tick();
        for (int i = 0; i < 4; i++) begin
            cpu_cti = (i == 3) ? 3'b111 : 3'b010;
            mem_ack = 1'b1;
            if (i == 1) begin mam_cyc = 1'b1; mam_stb = 1'b1; end
            @(negedge clk);
            chk($sformatf("burst%0d cpu_ack", i), 32'(cpu_ack_o), 1);
            chk($sformatf("burst%0d mam_ack", i), 32'(mam_ack_o), 0);
            chk($sformatf("burst%0d cti", i), 32'(mem_cti_o), (i == 3) ? 7 : 2);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0);
        cpu_cti = 3'b000;
        @(negedge clk);
        chk("burst end grant", 32'(grant_o), 2);
        tick();
        @(negedge clk);
        chk("burst gap grant", 32'(grant_o), 0);
        tick();
        @(negedge clk);
        chk("burst mam grant", 32'(grant_o), 1);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // watchdog: memory never answers the CPU
        drive(1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("wd%0d mem_cyc", k), 32'(mem_cyc_o), (k < 9) ? 1 : 0);
            chk($sformatf("wd%0d cpu_err", k), 32'(cpu_err_o), (k == 9) ? 1 : 0);
            chk($sformatf("wd%0d timeout", k), 32'(timeout_o), (k == 9) ? 1 : 0);
            tick();
        end
        mem_ack = 1'b1;
        @(negedge clk);
        chk("abort grant", 32'(grant_o), 0);
        chk("abort late ack", 32'(cpu_ack_o), 0);
        chk("abort err once", 32'(cpu_err_o), 0);
        chk("abort timeout once", 32'(timeout_o), 0);
        chk("abort mem_cyc", 32'(mem_cyc_o), 0);
        tick();
        @(negedge clk);
        chk("abort hold grant", 32'(grant_o), 0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("abort recover grant", 32'(grant_o), 1);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // asynchronous reset during a MAM read
        drive(1'b1, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("rstmid pre grant", 32'(grant_o), 1);
        chk("rstmid pre mem_cyc", 32'(mem_cyc_o), 1);
        #1;
        rstn = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("rstmid mem_cyc", 32'(mem_cyc_o), 0);
        chk("rstmid grant", 32'(grant_o), 0);
        chk("rstmid mam_ack", 32'(mam_ack_o), 0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("rstrel idle grant", 32'(grant_o), 0);
        tick();
        @(negedge clk);
        chk("rstrel mam grant", 32'(grant_o), 1);
        chk("rstrel mam_ack", 32'(mam_ack_o), 1);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
